// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (core / DMA) arbiter in front of a single-ported
// data memory. One transaction in flight at a time. Reads take LAT cycles
// from the m_en strobe to valid m_rdata.
// Optional feature: define DMEM_ARB_LOCK_EN to add the d_lock_i port, which lets
// the DMA hold the memory across back-to-back transactions.
module dmem_arbiter #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req_i,
    input  logic        c_we_i,
    input  logic [31:0] c_addr_i,
    input  logic [31:0] c_wdata_i,
    output logic        c_gnt_o,
    output logic        c_rvalid_o,
    output logic [31:0] c_rdata_o,
    output logic        stall_core_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
`ifdef DMEM_ARB_LOCK_EN
    input  logic        d_lock_i,
`endif
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        m_en_o,
    output logic        m_we_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    input  logic [31:0] m_rdata_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        owner_q;      // 1: DMA owns the transaction, 0: core
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic        last_dma_q;   // round-robin pointer: 1 when DMA was served last
    logic [2:0]  cnt_q;        // WAIT cycle counter, 0..LAT-1
    logic [31:0] c_rdata_q, d_rdata_q;

    logic lock_win, pick_dma, grant, wait_last, c_gnt, d_gnt, stall;

`ifdef DMEM_ARB_LOCK_EN
    // A locked DMA keeps the memory as long as it was the last one served.
    assign lock_win = last_dma_q & d_req_i & d_lock_i;
`else
    assign lock_win = 1'b0;
`endif

    // DMA wins when alone, on a tie when the core was served last, or on lock.
    assign pick_dma  = lock_win | (d_req_i & ~(c_req_i & last_dma_q));
    assign wait_last = (cnt_q == 3'(LAT - 1));

    // Next-state logic and combinational grant, requests sampled only in IDLE.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        c_gnt   = 1'b0;
        d_gnt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (c_req_i | d_req_i) begin
                    grant   = 1'b1;
                    c_gnt   = ~pick_dma;
                    d_gnt   = pick_dma;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = we_q ? IDLE : WAIT;
            WAIT:    if (wait_last) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Core stall: waiting for a grant, or owning a not-yet-answered access.
    always_comb begin
        stall = 1'b0;
        case (state_q)
            IDLE:        stall = c_req_i & ~c_gnt;
            ISSUE, WAIT: stall = owner_q ? c_req_i : 1'b1;
            RESP:        stall = owner_q & c_req_i;
            default:     stall = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Capture the winning request and advance the round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            last_dma_q <= 1'b1;
        end else if (grant) begin
            owner_q    <= pick_dma;
            we_q       <= pick_dma ? d_we_i    : c_we_i;
            addr_q     <= pick_dma ? d_addr_i  : c_addr_i;
            wdata_q    <= pick_dma ? d_wdata_i : c_wdata_i;
            last_dma_q <= pick_dma;
        end
    end

    // Count WAIT cycles; cleared while the access is being issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  cnt_q <= 3'd0;
        else if (state_q == ISSUE) cnt_q <= 3'd0;
        else if (state_q == WAIT)  cnt_q <= cnt_q + 3'd1;
    end

    // Latch read data into the owner's register on the last WAIT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
        end else if (state_q == WAIT && wait_last) begin
            if (owner_q) d_rdata_q <= m_rdata_i;
            else         c_rdata_q <= m_rdata_i;
        end
    end

    // Outputs. Grants and stall are masked during reset so every output is 0.
    assign c_gnt_o      = c_gnt & rst;
    assign d_gnt_o      = d_gnt & rst;
    assign stall_core_o = stall & rst;
    assign m_en_o       = (state_q == ISSUE);
    assign m_we_o       = m_en_o & we_q;
    assign m_addr_o     = m_en_o ? addr_q  : 32'h0;
    assign m_wdata_o    = m_en_o ? wdata_q : 32'h0;
    assign c_rvalid_o   = (state_q == RESP) & ~owner_q;
    assign d_rvalid_o   = (state_q == RESP) & owner_q;
    assign c_rdata_o    = c_rdata_q;
    assign d_rdata_o    = d_rdata_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a LAT=1 instance and a LAT=3 instance share inputs.
// Directed vector table, randomized traffic against a transaction-level model,
// and hand-written multi-cycle sequences (LAT=3 read, reset in WAIT, lock).
module tb_dmem_arbiter;

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;
    localparam int   LAT1 = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata, m_rdata;
`ifdef DMEM_ARB_LOCK_EN
    logic        d_lock;
`endif

    logic        c_gnt1, c_rv1, st1, d_gnt1, d_rv1, m_en1, m_we1, busy1;
    logic [31:0] c_rd1, d_rd1, m_a1, m_wd1;
    logic        c_gnt3, c_rv3, st3, d_gnt3, d_rv3, m_en3, m_we3, busy3;
    logic [31:0] c_rd3, d_rd3, m_a3, m_wd3;

    dmem_arbiter #(.LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
        .c_gnt_o(c_gnt1), .c_rvalid_o(c_rv1), .c_rdata_o(c_rd1), .stall_core_o(st1),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .d_lock_i(d_lock),
`endif
        .d_gnt_o(d_gnt1), .d_rvalid_o(d_rv1), .d_rdata_o(d_rd1),
        .m_en_o(m_en1), .m_we_o(m_we1), .m_addr_o(m_a1), .m_wdata_o(m_wd1),
        .m_rdata_i(m_rdata), .busy_o(busy1)
    );

    dmem_arbiter #(.LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
        .c_gnt_o(c_gnt3), .c_rvalid_o(c_rv3), .c_rdata_o(c_rd3), .stall_core_o(st3),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .d_lock_i(d_lock),
`endif
        .d_gnt_o(d_gnt3), .d_rvalid_o(d_rv3), .d_rdata_o(d_rd3),
        .m_en_o(m_en3), .m_we_o(m_we3), .m_addr_o(m_a3), .m_wdata_o(m_wd3),
        .m_rdata_i(m_rdata), .busy_o(busy3)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
`ifdef DMEM_ARB_LOCK_EN
        d_lock = 0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    typedef struct {
        logic cr, cw; logic [31:0] ca, cd;
        logic dr, dw; logic [31:0] da, dd;
        logic [31:0] mr;
        logic cg, dg, crv, drv, men, mwe; logic [31:0] ma, mwd;
        logic st, bz; logic [31:0] crd, drd;
    } vec_t;

    vec_t tv[11];

    // transaction-level reference model state
    int          k;            // cycles since the grant of the current transaction, 0 = free
    logic        t_own, t_we;  // owner (1 = DMA), write flag
    logic [31:0] t_a, t_d;
    logic        last_d;
    logic [31:0] rd[2];
    logic        pend[2], pwe[2], just_g[2];
    logic [31:0] pa[2], pd[2];

    initial begin
        // cycle-by-cycle directed vectors after reset, LAT=1 instance
        //          cr cw ca        cd  dr dw da        dd        mr            cg dg crv drv men mwe ma        mwd       st bz crd           drd
        tv[0]  = '{I, O, 32'h10, 32'h0, I, I, 32'h20, 32'h55, 32'h0,        I, O, O, O, O, O, 32'h0,  32'h0,  O, O, 32'h0,        32'h0};
        tv[1]  = '{O, O, 32'h0,  32'h0, I, I, 32'h20, 32'h55, 32'h0,        O, O, O, O, I, O, 32'h10, 32'h0,  I, I, 32'h0,        32'h0};
        tv[2]  = '{O, O, 32'h0,  32'h0, I, I, 32'h20, 32'h55, 32'hDEADBEEF, O, O, O, O, O, O, 32'h0,  32'h0,  I, I, 32'h0,        32'h0};
        tv[3]  = '{O, O, 32'h0,  32'h0, I, I, 32'h20, 32'h55, 32'h0,        O, O, I, O, O, O, 32'h0,  32'h0,  O, I, 32'hDEADBEEF, 32'h0};
        tv[4]  = '{I, O, 32'h14, 32'h0, I, I, 32'h20, 32'h55, 32'h0,        O, I, O, O, O, O, 32'h0,  32'h0,  I, O, 32'hDEADBEEF, 32'h0};
        tv[5]  = '{I, O, 32'h14, 32'h0, O, O, 32'h0,  32'h0,  32'h0,        O, O, O, O, I, I, 32'h20, 32'h55, I, I, 32'hDEADBEEF, 32'h0};
        tv[6]  = '{I, O, 32'h14, 32'h0, O, O, 32'h0,  32'h0,  32'h0,        I, O, O, O, O, O, 32'h0,  32'h0,  O, O, 32'hDEADBEEF, 32'h0};
        tv[7]  = '{O, O, 32'h0,  32'h0, O, O, 32'h0,  32'h0,  32'h0,        O, O, O, O, I, O, 32'h14, 32'h0,  I, I, 32'hDEADBEEF, 32'h0};
        tv[8]  = '{O, O, 32'h0,  32'h0, O, O, 32'h0,  32'h0,  32'h12345678, O, O, O, O, O, O, 32'h0,  32'h0,  I, I, 32'hDEADBEEF, 32'h0};
        tv[9]  = '{O, O, 32'h0,  32'h0, O, O, 32'h0,  32'h0,  32'h0,        O, O, I, O, O, O, 32'h0,  32'h0,  O, I, 32'h12345678, 32'h0};
        tv[10] = '{O, O, 32'h0,  32'h0, O, O, 32'h0,  32'h0,  32'h0,        O, O, O, O, O, O, 32'h0,  32'h0,  O, O, 32'h12345678, 32'h0};

        rst = 0;
        idle_inputs();
        c_req = 1; d_req = 1;   // requests during reset must not be granted
        #1;
        chk("rst c_gnt", c_gnt1, 0);
        chk("rst d_gnt", d_gnt1, 0);
        chk("rst stall", st1, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst busy", busy1, 0);
        chk("rst m_en", m_en1, 0);
        chk("rst c_rdata", c_rd1, 0);
        chk("rst d_rdata", d_rd1, 0);
        chk("rst c_rvalid", c_rv1, 0);
        chk("rst busy3", busy3, 0);
        idle_inputs();
        @(negedge clk);
        rst = 1;

        // ---- vector table ----
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            c_req = tv[i].cr; c_we = tv[i].cw; c_addr = tv[i].ca; c_wdata = tv[i].cd;
            d_req = tv[i].dr; d_we = tv[i].dw; d_addr = tv[i].da; d_wdata = tv[i].dd;
            m_rdata = tv[i].mr;
            #1;
            chk($sformatf("vec%0d c_gnt", i),    c_gnt1, tv[i].cg);
            chk($sformatf("vec%0d d_gnt", i),    d_gnt1, tv[i].dg);
            chk($sformatf("vec%0d c_rvalid", i), c_rv1,  tv[i].crv);
            chk($sformatf("vec%0d d_rvalid", i), d_rv1,  tv[i].drv);
            chk($sformatf("vec%0d m_en", i),     m_en1,  tv[i].men);
            chk($sformatf("vec%0d m_we", i),     m_we1,  tv[i].mwe);
            chk($sformatf("vec%0d m_addr", i),   m_a1,   tv[i].ma);
            chk($sformatf("vec%0d m_wdata", i),  m_wd1,  tv[i].mwd);
            chk($sformatf("vec%0d stall", i),    st1,    tv[i].st);
            chk($sformatf("vec%0d busy", i),     busy1,  tv[i].bz);
            chk($sformatf("vec%0d c_rdata", i),  c_rd1,  tv[i].crd);
            chk($sformatf("vec%0d d_rdata", i),  d_rd1,  tv[i].drd);
        end

        // ---- LAT=3 read: gnt T, m_en T+1, three WAIT cycles, rvalid T+5 ----
        do_reset();
        @(negedge clk);
        c_req = 1; c_we = 0; c_addr = 32'h40; m_rdata = 32'hA5A50003;
        #1;
        chk("lat3 c_gnt", c_gnt3, 1);
        @(negedge clk);
        c_req = 0;
        #1;
        chk("lat3 m_en", m_en3, 1);
        chk("lat3 m_addr", m_a3, 32'h40);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            #1;
            chk($sformatf("lat3 wait%0d busy", w), busy3, 1);
            chk($sformatf("lat3 wait%0d rvalid", w), c_rv3, 0);
            chk($sformatf("lat3 wait%0d stall", w), st3, 1);
        end
        @(negedge clk);
        #1;
        chk("lat3 c_rvalid", c_rv3, 1);
        chk("lat3 c_rdata", c_rd3, 32'hA5A50003);
        chk("lat3 stall", st3, 0);
        @(negedge clk);
        #1;
        chk("lat3 idle busy", busy3, 0);

        // ---- reset asserted in WAIT ----
        @(negedge clk);
        c_req = 1; c_addr = 32'h44; m_rdata = 32'h11112222;
        #1;
        chk("rstwait c_gnt", c_gnt3, 1);
        @(negedge clk);
        c_req = 0;
        @(negedge clk);
        #1;
        chk("rstwait in wait", busy3, 1);
        rst = 0;
        #1;
        chk("rstwait busy", busy3, 0);
        chk("rstwait c_rdata", c_rd3, 0);
        chk("rstwait stall", st3, 0);
        chk("rstwait m_en", m_en3, 0);
        chk("rstwait m_addr", m_a3, 0);
        chk("rstwait c_rvalid", c_rv3, 0);
        @(negedge clk);
        rst = 1;
        for (int w = 0; w < 6; w++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rstwait post%0d rvalid", w), c_rv3, 0);
            chk($sformatf("rstwait post%0d busy", w), busy3, 0);
        end

`ifdef DMEM_ARB_LOCK_EN
        // ---- DMA lock: three locked reads while the core keeps requesting ----
        do_reset();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            c_req = 1; c_addr = 32'h80; d_req = 1; d_we = 0; d_lock = 1;
            d_addr = 32'h100 + n; m_rdata = 32'hC0DE0000 + n;
            #1;
            chk($sformatf("lock%0d d_gnt", n), d_gnt1, 1);
            chk($sformatf("lock%0d c_gnt", n), c_gnt1, 0);
            chk($sformatf("lock%0d stall", n), st1, 1);
            d_req = 0;
            for (int w = 0; w < LAT1 + 2; w++) begin
                @(negedge clk);
                #1;
                chk($sformatf("lock%0d stall c%0d", n, w), st1, 1);
            end
            chk($sformatf("lock%0d d_rvalid", n), d_rv1, 1);
            chk($sformatf("lock%0d d_rdata", n), d_rd1, 32'hC0DE0000 + n);
        end
        @(negedge clk);
        d_lock = 0;
        #1;
        chk("lock end c_gnt", c_gnt1, 1);
        chk("lock end d_gnt", d_gnt1, 0);
`endif

        // ---- randomized traffic against the transaction model (LAT=1) ----
        do_reset();
        k = 0; last_d = 1; rd[0] = 0; rd[1] = 0; t_own = 0; t_we = 0; t_a = 0; t_d = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; pwe[p] = 0; pa[p] = 0; pd[p] = 0; just_g[p] = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic        any, win, rvc;
            logic        e_cg, e_dg, e_crv, e_drv, e_men, e_mwe, e_st, e_bz;
            logic [31:0] e_ma, e_mwd;
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && !just_g[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1;
                    pwe[p]  = 1'($urandom_range(0, 1));
                    pa[p]   = $urandom;
                    pd[p]   = $urandom;
                end
                just_g[p] = 0;
            end
            c_req = pend[0]; c_we = pwe[0]; c_addr = pa[0]; c_wdata = pd[0];
            d_req = pend[1]; d_we = pwe[1]; d_addr = pa[1]; d_wdata = pd[1];
            m_rdata = $urandom;
            #1;
            any = pend[0] | pend[1];
            win = (pend[0] & pend[1]) ? ~last_d : pend[1];
            e_cg = 0; e_dg = 0; e_crv = 0; e_drv = 0; e_men = 0; e_mwe = 0;
            e_ma = 0; e_mwd = 0; e_st = 0; e_bz = 0; rvc = 0;
            if (k == 0) begin
                e_cg = any & ~win;
                e_dg = any & win;
                e_st = pend[0] & ~e_cg;
            end else begin
                e_bz  = 1;
                e_men = (k == 1);
                e_mwe = e_men & t_we;
                e_ma  = e_men ? t_a : 32'h0;
                e_mwd = e_men ? t_d : 32'h0;
                rvc   = !t_we && (k == LAT1 + 2);
                e_crv = rvc & ~t_own;
                e_drv = rvc & t_own;
                e_st  = t_own ? pend[0] : ~rvc;
            end
            chk($sformatf("rnd%0d c_gnt", cyc),    c_gnt1, e_cg);
            chk($sformatf("rnd%0d d_gnt", cyc),    d_gnt1, e_dg);
            chk($sformatf("rnd%0d c_rvalid", cyc), c_rv1,  e_crv);
            chk($sformatf("rnd%0d d_rvalid", cyc), d_rv1,  e_drv);
            chk($sformatf("rnd%0d m_en", cyc),     m_en1,  e_men);
            chk($sformatf("rnd%0d m_we", cyc),     m_we1,  e_mwe);
            chk($sformatf("rnd%0d m_addr", cyc),   m_a1,   e_ma);
            chk($sformatf("rnd%0d m_wdata", cyc),  m_wd1,  e_mwd);
            chk($sformatf("rnd%0d stall", cyc),    st1,    e_st);
            chk($sformatf("rnd%0d busy", cyc),     busy1,  e_bz);
            chk($sformatf("rnd%0d c_rdata", cyc),  c_rd1,  rd[0]);
            chk($sformatf("rnd%0d d_rdata", cyc),  d_rd1,  rd[1]);
            // advance the model to the next cycle
            if (k == 0) begin
                if (any) begin
                    last_d = win;
                    t_own  = win;
                    t_we   = pwe[win];
                    t_a    = pa[win];
                    t_d    = pd[win];
                    pend[win]   = 0;
                    just_g[win] = 1;
                    k = 1;
                end
            end else begin
                if (!t_we && k == LAT1 + 1) rd[t_own] = m_rdata;
                if (t_we ? (k == 1) : (k == LAT1 + 2)) k = 0;
                else k = k + 1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter LAT, default 1, meaning memory read latency in cycles from m_en to valid m_rdata; legal range 1..4.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 c_req, c_we  input  1 each  core load/store request and write flag.
REQ-005 c_addr, c_wdata  input  32 each  core address and store data.
REQ-006 c_gnt, c_rvalid  output  1 each  core grant pulse and read-data-valid pulse.
REQ-007 c_rdata  output  32  core load data.
REQ-008 stall_core  output  1  freezes the core pipeline while its access is outstanding.
REQ-009 d_req, d_we  input  1 each  DMA/debug request and write flag.
REQ-010 d_addr, d_wdata  input  32 each  DMA address and store data.
REQ-011 d_gnt, d_rvalid  output  1 each  DMA grant pulse and read-data-valid pulse.
REQ-012 d_rdata  output  32  DMA read data.
REQ-013 d_lock  input  1  DMA bus lock request; present only with DMEM_ARB_LOCK_EN.
REQ-014 m_en, m_we  output  1 each  data-memory access strobe and write enable.
REQ-015 m_addr, m_wdata  output  32 each  data-memory address and write data.
REQ-016 m_rdata  input  32  data-memory read data.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-019 IDLE: if any req is high, grant a winner combinationally (x_gnt high that cycle), capture owner/we/addr/wdata, and go to ISSUE.
REQ-020 Arbitration: single requester wins; both high -> the port not served last wins (round-robin pointer updated on each grant).
REQ-021 Requests are sampled only in IDLE; a requester deasserts req the cycle after gnt or it is treated as a new request.
REQ-022 ISSUE: m_en=1 for exactly one cycle with captured m_we/m_addr/m_wdata; write -> IDLE next cycle; read -> WAIT.
REQ-023 WAIT: stay exactly LAT cycles; on the last WAIT cycle capture m_rdata into the owner's rdata register; go to RESP.
REQ-024 RESP: owner's x_rvalid=1 for one cycle; go to IDLE; no grant in RESP.
REQ-025 Read timing: gnt in cycle T, m_en in T+1, x_rvalid in T+2+LAT; write: gnt T, m_en/m_we in T+1, next grant no earlier than T+2.
REQ-026 x_rdata holds its last captured value until the next read for that port.
REQ-027 m_en, m_we, m_addr, and m_wdata are 0 outside ISSUE.
REQ-028 stall_core = 1 when c_req is high in IDLE without c_gnt, or the core owns an ISSUE, WAIT, or RESP-pending read (low in the c_rvalid cycle), or the core owns an ISSUE write.
REQ-029 stall_core = 1 while c_req waits on a DMA transaction.

Reset
REQ-030 rst low forces IDLE immediately, drops any in-flight transaction, and drives all outputs to 0 (rdata registers 32'h0).
REQ-031 Reset sets the round-robin pointer to "DMA served last", so the core wins the first tie.

Configuration
REQ-032 DMEM_ARB_LOCK_EN defined: d_lock port exists; while the DMA was granted last and d_req&d_lock is high in IDLE, the DMA wins regardless of c_req; lock ends when d_lock is sampled low in IDLE.
REQ-033 DMEM_ARB_LOCK_EN undefined: no d_lock port; pure round-robin per REQ-020.

Verification
REQ-034 LAT=1, core read addr 0x10 at T, m_rdata=0xDEADBEEF -> c_gnt T, m_en T+1, c_rvalid and c_rdata=0xDEADBEEF at T+3, stall_core low at T+3.
REQ-035 Core and DMA request together after reset -> c_gnt first; a repeat simultaneous request after IDLE -> d_gnt.
REQ-036 DMA write addr 0x20 data 0x55 -> m_en=m_we=1, m_addr=0x20, m_wdata=0x55 for one cycle, no d_rvalid, busy low next cycle.
REQ-037 LAT=3 read -> exactly 3 WAIT cycles, rvalid at T+5; rst pulled low in WAIT -> IDLE at once, no rvalid, all outputs 0.
REQ-038 With DMEM_ARB_LOCK_EN, d_lock high for 3 DMA reads while c_req is high -> 3 consecutive d_gnt, stall_core high throughout, and c_gnt on the first IDLE after d_lock falls.
